// File: rtl/cursor_overlay_if.sv
// Host register write port for cursor_overlay: a one-cycle write strobe
// carrying a 2-bit register select and 8-bit data.
interface cursor_overlay_if;
  logic       regWr;
  logic [1:0] regAddr;
  logic [7:0] regData;

  modport master (output regWr, regAddr, regData);
  modport slave  (input  regWr, regAddr, regData);
endinterface

// File: rtl/cursor_overlay.sv
// Text-cursor overlay between pixel generator and VGA output: inverts the glyph
// pixel inside a host-positioned, optionally blinking cell with 1-cycle latency.
// Optional macro CURSOR_SHAPE_REG_EN makes the cursor scanline span writable (addr3).
module cursor_overlay #(
  parameter int BLINK_FRAMES = 16,
  parameter int NUM_COLS     = 80,
  parameter int NUM_ROWS     = 30
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   frameStart,
  input  logic                   lineStart,
  input  logic                   nVisIn,
  input  logic                   hSyncIn,
  input  logic                   vSyncIn,
  input  logic                   pixelIn,
  input  logic [3:0]             fgIn,
  input  logic [3:0]             bgIn,
  cursor_overlay_if.slave        host,
  output logic                   pixelOut,
  output logic [3:0]             fgOut,
  output logic [3:0]             bgOut,
  output logic                   hSyncOut,
  output logic                   vSyncOut,
  output logic                   nVisOut
);

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] COL_LIMIT  = 8'(NUM_COLS);
  localparam logic [5:0] ROW_LIMIT  = 6'(NUM_ROWS);

  logic [6:0] cur_col_q, cur_col_d;
  logic [4:0] cur_row_q, cur_row_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic [2:0] dot_q, dot_d;
  logic [6:0] col_q, col_d;
  logic [3:0] scan_q, scan_d;
  logic [4:0] row_q, row_d;
  logic       first_q, first_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       blink_q, blink_d;

  logic       pixel_out_q, pixel_out_d;
  logic [3:0] fg_out_q, bg_out_q;
  logic       hsync_out_q, vsync_out_q, nvis_out_q;

  logic [2:0] dot_eff;
  logic [6:0] col_eff;
  logic [3:0] scan_eff;
  logic [4:0] row_eff;
  logic       first_eff;
  logic [3:0] start_line, end_line;
  logic       in_bounds, hit;

`ifdef CURSOR_SHAPE_REG_EN
  logic [7:0] shape_q, shape_d;
  assign start_line = shape_q[3:0];
  assign end_line   = shape_q[7:4];
`else
  logic unused_reg_bits;
  assign unused_reg_bits = host.regData[7];
  assign start_line = 4'd14;
  assign end_line   = 4'd15;
`endif

  assign in_bounds = ({1'b0, cur_col_q} < COL_LIMIT) && ({1'b0, cur_row_q} < ROW_LIMIT);

  always_comb begin
    cur_col_d   = cur_col_q;
    cur_row_d   = cur_row_q;
    ctrl_d      = ctrl_q;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
`ifdef CURSOR_SHAPE_REG_EN
    shape_d     = shape_q;
`endif

    // Position of the current dot: frameStart is applied before lineStart.
    dot_eff   = lineStart ? 3'd0 : dot_q;
    col_eff   = lineStart ? 7'd0 : col_q;
    scan_eff  = frameStart ? 4'd0 : scan_q;
    row_eff   = frameStart ? 5'd0 : row_q;
    first_eff = frameStart | first_q;
    if (lineStart) begin
      if (first_eff) begin
        first_eff = 1'b0;
      end else begin
        if (scan_eff == 4'd15 && row_eff != 5'd31) row_eff = row_eff + 5'd1;
        scan_eff = scan_eff + 4'd1;
      end
    end

    dot_d   = dot_eff;
    col_d   = col_eff;
    if (!nVisIn) begin
      dot_d = dot_eff + 3'd1;
      if (dot_eff == 3'd7 && col_eff != 7'd127) col_d = col_eff + 7'd1;
    end
    scan_d  = scan_eff;
    row_d   = row_eff;
    first_d = first_eff;

    if (frameStart) begin
      if (frame_cnt_q == BLINK_LAST) begin
        frame_cnt_d = 8'd0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end

    // Moving the cursor restarts the blink cycle visible, overriding frameStart.
    if (host.regWr) begin
      case (host.regAddr)
        2'd0: begin
          cur_col_d   = host.regData[6:0];
          frame_cnt_d = 8'd0;
          blink_d     = 1'b1;
        end
        2'd1: begin
          cur_row_d   = host.regData[4:0];
          frame_cnt_d = 8'd0;
          blink_d     = 1'b1;
        end
        2'd2: ctrl_d = host.regData[1:0];
        2'd3: begin
`ifdef CURSOR_SHAPE_REG_EN
          shape_d = host.regData;
`endif
        end
      endcase
    end

    hit = ctrl_q[0] && in_bounds && (col_eff == cur_col_q) && (row_eff == cur_row_q)
          && (scan_eff >= start_line) && (scan_eff <= end_line)
          && (blink_q || !ctrl_q[1]) && !nVisIn;
    pixel_out_d = pixelIn ^ hit;
  end

  // Output stage boundary: all outputs registered, 1 cycle after inputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cur_col_q   <= 7'd0;
      cur_row_q   <= 5'd0;
      ctrl_q      <= 2'b11;
      dot_q       <= 3'd0;
      col_q       <= 7'd0;
      scan_q      <= 4'd0;
      row_q       <= 5'd0;
      first_q     <= 1'b0;
      frame_cnt_q <= 8'd0;
      blink_q     <= 1'b1;
`ifdef CURSOR_SHAPE_REG_EN
      shape_q     <= 8'hFE;
`endif
      pixel_out_q <= 1'b0;
      fg_out_q    <= 4'd0;
      bg_out_q    <= 4'd0;
      hsync_out_q <= 1'b1;
      vsync_out_q <= 1'b1;
      nvis_out_q  <= 1'b1;
    end else begin
      cur_col_q   <= cur_col_d;
      cur_row_q   <= cur_row_d;
      ctrl_q      <= ctrl_d;
      dot_q       <= dot_d;
      col_q       <= col_d;
      scan_q      <= scan_d;
      row_q       <= row_d;
      first_q     <= first_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
`ifdef CURSOR_SHAPE_REG_EN
      shape_q     <= shape_d;
`endif
      pixel_out_q <= pixel_out_d;
      fg_out_q    <= fgIn;
      bg_out_q    <= bgIn;
      hsync_out_q <= hSyncIn;
      vsync_out_q <= vSyncIn;
      nvis_out_q  <= nVisIn;
    end
  end

  assign pixelOut = pixel_out_q;
  assign fgOut    = fg_out_q;
  assign bgOut    = bg_out_q;
  assign hSyncOut = hsync_out_q;
  assign vSyncOut = vsync_out_q;
  assign nVisOut  = nvis_out_q;

endmodule

// File: tb/tb_cursor_overlay.sv
// Directed testbench for cursor_overlay using short synthetic frames and
// hand-derived cursor cell positions (BLINK_FRAMES overridden to 4).
module tb_cursor_overlay;

  logic       clk = 1'b0;
  logic       nrst;
  logic       frameStart, lineStart, nVisIn, hSyncIn, vSyncIn, pixelIn;
  logic [3:0] fgIn, bgIn;
  logic       pixelOut, hSyncOut, vSyncOut, nVisOut;
  logic [3:0] fgOut, bgOut;

  int n_checks = 0;
  int n_errors = 0;

  cursor_overlay_if host_if ();

  cursor_overlay #(.BLINK_FRAMES(4), .NUM_COLS(80), .NUM_ROWS(30)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .frameStart (frameStart),
    .lineStart  (lineStart),
    .nVisIn     (nVisIn),
    .hSyncIn    (hSyncIn),
    .vSyncIn    (vSyncIn),
    .pixelIn    (pixelIn),
    .fgIn       (fgIn),
    .bgIn       (bgIn),
    .host       (host_if.slave),
    .pixelOut   (pixelOut),
    .fgOut      (fgOut),
    .bgOut      (bgOut),
    .hSyncOut   (hSyncOut),
    .vSyncOut   (vSyncOut),
    .nVisOut    (nVisOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {20'd0, pixelOut, fgOut, bgOut, hSyncOut, vSyncOut, nVisOut};
  endfunction

  // Clock once and compare outputs with the inputs just applied (pixel optionally inverted).
  task automatic tick_check(input string tag, input logic inv);
    logic [11:0] exp_v;
    @(posedge clk);
    #1;
    exp_v = {pixelIn ^ inv, fgIn, bgIn, hSyncIn, vSyncIn, nVisIn};
    check(tag, out_vec(), {20'd0, exp_v});
  endtask

  task automatic idle_inputs();
    frameStart = 1'b0;
    lineStart  = 1'b0;
    nVisIn     = 1'b1;
    hSyncIn    = 1'b1;
    vSyncIn    = 1'b1;
    pixelIn    = 1'b0;
    fgIn       = 4'd0;
    bgIn       = 4'd0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    idle_inputs();
    host_if.regWr   = 1'b1;
    host_if.regAddr = a;
    host_if.regData = d;
    tick_check("reg_write", 1'b0);
    host_if.regWr   = 1'b0;
  endtask

  // One synthetic frame: optional frameStart blank cycle, then nlines lines of
  // ndots visible dots plus 4 blanking dots. Cursor cell expected at
  // dots exp_col*8..+7 on lines exp_row*16+lo..exp_row*16+hi when exp_vis.
  task automatic run_frame(input string name, input int nlines, input int ndots,
                           input int exp_col, input int exp_row, input int lo, input int hi,
                           input bit exp_vis, input bit fs_with_ls, input bit fs_wr,
                           input logic [7:0] wr_col);
    logic inv;
    if (!fs_with_ls) begin
      idle_inputs();
      frameStart = 1'b1;
      vSyncIn    = 1'b0;
      if (fs_wr) begin
        host_if.regWr   = 1'b1;
        host_if.regAddr = 2'd0;
        host_if.regData = wr_col;
      end
      tick_check({name, " fs"}, 1'b0);
      host_if.regWr = 1'b0;
    end
    for (int ln = 0; ln < nlines; ln++) begin
      for (int d = 0; d < ndots + 4; d++) begin
        frameStart = fs_with_ls && ln == 0 && d == 0;
        lineStart  = (d == 0);
        vSyncIn    = 1'b1;
        fgIn       = 4'(d);
        bgIn       = 4'(ln);
        if (d < ndots) begin
          nVisIn  = 1'b0;
          hSyncIn = 1'b1;
          pixelIn = ((d + ln) % 3) == 0;
          inv = exp_vis && (ln / 16 == exp_row) && (ln % 16 >= lo) && (ln % 16 <= hi)
                && (d / 8 == exp_col);
        end else begin
          nVisIn  = 1'b1;
          hSyncIn = (d != ndots + 1);
          pixelIn = d[0];
          inv = 1'b0;
        end
        tick_check($sformatf("%s L%0d D%0d", name, ln, d), inv);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sh_lo, sh_hi;
    bit sh_vis;
    host_if.regWr   = 1'b0;
    host_if.regAddr = 2'd0;
    host_if.regData = 8'd0;
    nrst = 1'b0;
    // Non-reset-looking inputs while reset is held
    frameStart = 1'b0;
    lineStart  = 1'b0;
    nVisIn     = 1'b0;
    hSyncIn    = 1'b0;
    vSyncIn    = 1'b0;
    pixelIn    = 1'b1;
    fgIn       = 4'hF;
    bgIn       = 4'hF;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset_outputs", out_vec(), 32'h007);
    end
    nrst = 1'b1;
    tick_check("post_reset_a", 1'b0);
    hSyncIn = 1'b1; fgIn = 4'h5; bgIn = 4'hA; pixelIn = 1'b0;
    tick_check("post_reset_b", 1'b0);
    vSyncIn = 1'b1; nVisIn = 1'b1; fgIn = 4'h3; pixelIn = 1'b1;
    tick_check("post_reset_c", 1'b0);

    // Steady cursor, blink disabled
    wr_reg(2'd0, 8'd5);
    wr_reg(2'd1, 8'd2);
    wr_reg(2'd2, 8'h01);
    run_frame("steady", 48, 48, 5, 2, 14, 15, 1'b1, 1'b0, 1'b0, 8'd0);
    run_frame("fs_ls", 48, 48, 5, 2, 14, 15, 1'b1, 1'b1, 1'b0, 8'd0);

    // Boundaries
    wr_reg(2'd0, 8'd79);
    wr_reg(2'd1, 8'd0);
    run_frame("col79", 16, 640, 79, 0, 14, 15, 1'b1, 1'b0, 1'b0, 8'd0);
    wr_reg(2'd0, 8'd80);
    run_frame("col80", 16, 656, 80, 0, 14, 15, 1'b0, 1'b0, 1'b0, 8'd0);
    wr_reg(2'd0, 8'd0);
    wr_reg(2'd1, 8'd30);
    run_frame("row30", 496, 8, 0, 30, 14, 15, 1'b0, 1'b0, 1'b0, 8'd0);

    // Cursor shape register
    wr_reg(2'd0, 8'd1);
    wr_reg(2'd1, 8'd0);
    wr_reg(2'd3, 8'h50);
`ifdef CURSOR_SHAPE_REG_EN
    sh_lo = 0; sh_hi = 5; sh_vis = 1'b1;
`else
    sh_lo = 14; sh_hi = 15; sh_vis = 1'b1;
`endif
    run_frame("shape50", 16, 16, 1, 0, sh_lo, sh_hi, sh_vis, 1'b0, 1'b0, 8'd0);
    wr_reg(2'd3, 8'h05);
`ifdef CURSOR_SHAPE_REG_EN
    sh_vis = 1'b0;
`else
    sh_vis = 1'b1;
`endif
    run_frame("shape05", 16, 16, 1, 0, 14, 15, sh_vis, 1'b0, 1'b0, 8'd0);
    wr_reg(2'd3, 8'hFE);

    // Blink with 4-frame half-period; col write restarts the cycle visible
    wr_reg(2'd2, 8'h03);
    wr_reg(2'd1, 8'd0);
    wr_reg(2'd0, 8'd5);
    run_frame("blink1", 16, 48, 5, 0, 14, 15, 1'b1, 1'b0, 1'b0, 8'd0);
    run_frame("blink2", 16, 48, 5, 0, 14, 15, 1'b1, 1'b0, 1'b0, 8'd0);
    run_frame("blink3", 16, 48, 5, 0, 14, 15, 1'b1, 1'b0, 1'b0, 8'd0);
    run_frame("blink4", 16, 48, 5, 0, 14, 15, 1'b0, 1'b0, 1'b0, 8'd0);
    run_frame("blink5", 16, 48, 5, 0, 14, 15, 1'b0, 1'b0, 1'b0, 8'd0);
    run_frame("blink6", 16, 48, 5, 0, 14, 15, 1'b0, 1'b0, 1'b0, 8'd0);
    run_frame("blink7_wr", 16, 48, 5, 0, 14, 15, 1'b1, 1'b0, 1'b1, 8'd5);
    run_frame("blink8", 16, 48, 5, 0, 14, 15, 1'b1, 1'b0, 1'b0, 8'd0);
    run_frame("blink9", 16, 48, 5, 0, 14, 15, 1'b1, 1'b0, 1'b0, 8'd0);
    run_frame("blink10", 16, 48, 5, 0, 14, 15, 1'b1, 1'b0, 1'b0, 8'd0);
    run_frame("blink11_wr_wrap", 16, 48, 5, 0, 14, 15, 1'b1, 1'b0, 1'b1, 8'd5);
    run_frame("blink12", 16, 48, 5, 0, 14, 15, 1'b1, 1'b0, 1'b0, 8'd0);
    run_frame("blink13", 16, 48, 5, 0, 14, 15, 1'b1, 1'b0, 1'b0, 8'd0);
    run_frame("blink14", 16, 48, 5, 0, 14, 15, 1'b1, 1'b0, 1'b0, 8'd0);
    run_frame("blink15", 16, 48, 5, 0, 14, 15, 1'b0, 1'b0, 1'b0, 8'd0);

    // Reset asserted mid-line, then recovery with reset register values
    nVisIn = 1'b0; pixelIn = 1'b1; fgIn = 4'h5; bgIn = 4'hA; hSyncIn = 1'b0; vSyncIn = 1'b0;
    tick_check("midline_a", 1'b0);
    tick_check("midline_b", 1'b0);
    #3;
    nrst = 1'b0;
    #1;
    check("midline_reset_async", out_vec(), 32'h007);
    @(posedge clk);
    #1;
    check("midline_reset_held", out_vec(), 32'h007);
    nrst = 1'b1;
    idle_inputs();
    run_frame("after_reset", 16, 16, 0, 0, 14, 15, 1'b1, 1'b0, 1'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cursor_overlay.md
Name: cursor_overlay

Overview:
- Pipeline stage between the pixel generator and the VGA output stage.
- Consumes per-dot pixel, colour and timing signals from the pixel generator.
- Inverts the glyph pixel inside a host-positioned, optionally blinking text cursor cell.
- Forwards everything to the output stage with a fixed 1-cycle latency; host programs position and control through a small register port.

Parameters:
BLINK_FRAMES, 16, frames per blink half-period (2..255)
NUM_COLS, 80, character columns per line
NUM_ROWS, 30, character rows per frame

Ports:
clk  input  1  25.175 MHz dot clock
nrst  input  1  reset, asynchronous, active-low
frameStart  input  1  1-cycle pulse once per frame, before first visible line
lineStart  input  1  1-cycle pulse coincident with first visible dot of each line
nVisIn  input  1  0 = current dot visible
hSyncIn  input  1  horizontal sync from timing
vSyncIn  input  1  vertical sync from timing
pixelIn  input  1  glyph pixel (1 = foreground)
fgIn  input  4  foreground {I,R,G,B}
bgIn  input  4  background {I,R,G,B}
regWr  input  1  host register write strobe, 1 cycle
regAddr  input  2  register select
regData  input  8  register write data
pixelOut  output  1  pixel after cursor overlay
fgOut  output  4  delayed fgIn
bgOut  output  4  delayed bgIn
hSyncOut  output  1  delayed hSyncIn
vSyncOut  output  1  delayed vSyncIn
nVisOut  output  1  delayed nVisIn

Behaviour:
- Clock/reset: one clock, clk; nrst asynchronous active-low.
- Reset values:
  - Outputs: pixelOut=0, fgOut=0, bgOut=0, hSyncOut=1, vSyncOut=1, nVisOut=1.
  - Registers: curCol=0, curRow=0, ctrl=0x03.
  - Counters: all 0; blinkPhase=1.
- Latency: every output is registered, exactly 1 cycle after its input. Sync, colour and nVis pass through unmodified.
- Registers (write-only, effective the cycle after regWr):
  - addr0: curCol = regData[6:0].
  - addr1: curRow = regData[4:0].
  - addr2: ctrl; bit0 = cursor enable, bit1 = blink enable.
  - addr3: shape (optional feature only; otherwise ignored).
- Column tracking:
  - Effective column = 0 and dot index = 0 on a lineStart cycle.
  - Otherwise: dot index 0..7 increments on each visible cycle (nVisIn=0); column increments on dot-index wrap 7→0.
  - Column saturates at 127.
- Row tracking:
  - frameStart clears scanline (0..15) and row, and sets firstLine.
  - lineStart with firstLine set: clear firstLine, no increment.
  - lineStart otherwise: scanline++. On wrap 15→0, row++ (row saturates at 31).
- Hit condition: ctrl.bit0, and effective column == curCol, and row == curRow, and startLine <= scanline <= endLine, and (blinkPhase or !ctrl.bit1), and nVisIn=0.
  - On hit: pixelOut = ~pixelIn; otherwise pixelOut = pixelIn.
  - startLine > endLine → never hits.
  - curCol >= NUM_COLS or curRow >= NUM_ROWS → never visible.
- Blink:
  - Frame counter increments on frameStart. At BLINK_FRAMES-1 it wraps to 0 and toggles blinkPhase.
  - Write to addr0/addr1 clears frame counter and sets blinkPhase=1; this write wins over a simultaneous frameStart.
- Simultaneous frameStart and lineStart: frameStart processing first, then lineStart treated as the first line (scanline 0, row 0).
- Reset asserted mid-line: outputs return to reset values immediately; tracking resumes correctly from the next frameStart.

Optional Feature:
- Macro CURSOR_SHAPE_REG_EN.
- Defined:
  - addr3 is writable: startLine = regData[3:0], endLine = regData[7:4].
  - Reset value 0xFE (start 14, end 15).
- Undefined:
  - startLine=14, endLine=15 fixed; addr3 writes ignored; no shape register storage.

Test Plan:
- Reset: hold nrst=0 → pixelOut=0, fgOut=0, hSyncOut=1, vSyncOut=1, nVisOut=1. Release → any input toggle appears on outputs exactly 1 cycle later.
- Blink disabled, curCol=5, curRow=2, ctrl=0x01, pixelIn=0 → pixelOut=1 only for dots 40..47 on scanlines 14,15 of row 2 (frame lines 46,47); pixelOut=0 everywhere else.
- Blink: ctrl=0x03, BLINK_FRAMES=4 → cursor visible frames 0-3, hidden frames 4-7, visible 8-11. Write curCol in frame 5 → visible again from that write.
- Boundary: curCol=79 → inverts dots 632..639 only. curCol=80 or curRow=30 → no inversion anywhere in frame.
- Simultaneous: regWr addr0 in same cycle as frameStart with counter at BLINK_FRAMES-1 → blinkPhase=1, counter=0 (no toggle).
- With CURSOR_SHAPE_REG_EN: write addr3=0x50 → inversion on scanlines 0..5. Write 0x05 → no inversion. Without macro, same writes → scanlines 14..15 unchanged.
